serial_shift_endpoint: RTL and testbench
========================================

// Module: serial_shift_endpoint
// PURPOSE
//  Datapath-side partner of the controller's bit-serial word transfer.
//  Holds the R0..R3 register file and a shift-left-through-carry ALU path.
//  Each controller shift beat consumes one CIN bit (receive) and exposes the outgoing MSB on C (transmit).
//  Frames the beats into 8-bit words and reports completion or protocol error.
// PARAMETERS
//  WIDTH    8   register/word width, in bits; also the number of beats per frame
//  CNT_W    4   bit-counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  T3          in   1       clock; all state updates on posedge T3
//  CLR         in   1       synchronous reset, active-high
//  D_IN        in   WIDTH   switch data for SBUS writes
//  SBUS        in   1       write D_IN to R[RD]
//  ABUS        in   1       ALU result drives internal bus
//  DRW         in   1       write internal bus to R[RD]
//  RD          in   2       destination/source register select
//  S           in   4       ALU function select
//  M           in   1       ALU logic mode (1=logic, 0=arith)
//  CIN         in   1       carry-in, active-low: carry value = ~CIN
//  LDC         in   1       load C flag from ALU carry-out
//  LDZ         in   1       load Z flag from (result==0)
//  RD_VAL      out  WIDTH   R[RD], combinational read
//  C           out  1       carry flag
//  Z           out  1       zero flag
//  BIT_CNT     out  CNT_W   shift beats received in current frame
//  FRAME_DONE  out  1       one-cycle pulse: WIDTH beats completed
//  FRAME_ERR   out  1       one-cycle pulse: frame aborted or bus conflict
// BEHAVIOUR
//  - Reset (CLR=1 at posedge T3):
//    - R0..R3=0, C=0, Z=0, BIT_CNT=0, FRAME_DONE=0, FRAME_ERR=0, FSM=IDLE.
//    - CLR mid-frame discards the partial frame; no error pulse.
//  - ALU (combinational, A=R[RD]):
//    - S=1100,M=0 (SHIFT): {cout,res}=A+A+~CIN, i.e. res={A[W-2:0],~CIN}, cout=A[W-1].
//    - S=1111,M=1 (PASS): res=A, cout=0.
//    - S=1001,M=0 (INC): {cout,res}=A+1; the carry-in is ignored.
//    - Any other S/M: res=A, cout=0.
//  - Write, registered with 1-cycle latency:
//    - SBUS&!ABUS: R[RD]<=D_IN.
//    - ABUS&DRW&!SBUS: R[RD]<=res.
//    - SBUS&ABUS: no write; FRAME_ERR pulses.
//  - Flags:
//    - LDC: C<=cout.
//    - LDZ: Z<=(res==0).
//    - Flags update only on a valid ALU write or with LDC/LDZ alone (no write).
//  - Shift beat = ABUS&DRW&!SBUS with SHIFT decode.
//  - FSM IDLE/SHIFT/DONE:
//    - IDLE: beat -> SHIFT, BIT_CNT<=1.
//    - SHIFT: beat -> BIT_CNT+1; on the beat making BIT_CNT==WIDTH -> DONE.
//    - DONE: lasts one cycle with FRAME_DONE=1, BIT_CNT holds WIDTH, then -> IDLE, BIT_CNT<=0.
//    - DONE + beat same cycle: beat counts as first of a new frame (-> SHIFT, BIT_CNT<=1), FRAME_DONE still 1.
//    - SHIFT + non-shift write to any register, or beat with a different RD than the frame's first beat:
//      write still performed, FRAME_ERR=1, -> IDLE, BIT_CNT<=0.
//    - Idle cycles (no write) in SHIFT: hold; no timeout.
//  - Wrap: BIT_CNT never exceeds WIDTH; the frame RD is latched on the first beat.
//  - Outputs FRAME_DONE/FRAME_ERR are registered; C/Z/BIT_CNT are registered.
// STRUCTURE
//  - Shared package hdcpu_pkg:
//    - ALU codes: S_SHIFT=4'b1100, S_PASS=4'b1111, S_INC=4'b1001.
//    - FSM state enum {ST_IDLE, ST_SHIFT, ST_DONE}.
//    - Register index constants R0..R3.
//  - One sub-module: endpoint_alu (combinational A,S,M,CIN -> res,cout).
//  - The register file, flags and frame FSM stay in this module.
// TESTING
//  1. CLR=1 with R3=8'hFF, mid-frame BIT_CNT=3
//     -> next cycle R3=0, C=0, Z=0, BIT_CNT=0, no FRAME_ERR.
//  2. SBUS D_IN=8'hA5 RD=3, then 8 SHIFT beats with CIN=1, LDC=1
//     -> C sequence 1,0,1,0,0,1,0,1; R3=8'h00; Z=1 if LDZ; FRAME_DONE on the cycle after beat 8.
//  3. R3=0, 8 beats with CIN sequence 0,1,0,1,0,1,0,1 (carry 1,0,1,0,...)
//     -> R3=8'hAA, BIT_CNT 1..8, FRAME_DONE once.
//  4. 3 beats on RD=3, then PASS write to RD=1
//     -> R1 written, FRAME_ERR pulse, BIT_CNT=0, IDLE.
//  5. SBUS&ABUS&DRW together -> no register changes, FRAME_ERR=1 for one cycle.
//  6. Beat 8 followed immediately by a beat
//     -> FRAME_DONE=1 and BIT_CNT=1 the following cycle, R shifted twice.

Source files
------------

// File: rtl/hdcpu_pkg.sv
// Shared definitions for the bit-serial endpoint: ALU function codes,
// frame FSM states and register indices.
package hdcpu_pkg;

  localparam logic [3:0] S_SHIFT = 4'b1100;
  localparam logic [3:0] S_PASS  = 4'b1111;
  localparam logic [3:0] S_INC   = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam logic [1:0] R0 = 2'd0;
  localparam logic [1:0] R1 = 2'd1;
  localparam logic [1:0] R2 = 2'd2;
  localparam logic [1:0] R3 = 2'd3;

endpackage

// File: rtl/endpoint_alu.sv
// Combinational ALU for the endpoint: shift-left-through-carry, pass and
// increment. Carry-in pin is active-low.
module endpoint_alu
  import hdcpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic [WIDTH-1:0] res,
  output logic             cout
);

  always_comb begin
    res  = a;
    cout = 1'b0;
    if (!m && s == S_SHIFT) begin
      {cout, res} = {a, ~cin};
    end else if (!m && s == S_INC) begin
      {cout, res} = {1'b0, a} + (WIDTH + 1)'(1);
    end else if (m && s == S_PASS) begin
      res  = a;
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/serial_shift_endpoint.sv
// Datapath partner of the bit-serial word transfer: R0..R3, C/Z flags and
// the frame tracker that turns shift beats into WIDTH-bit words.
module serial_shift_endpoint
  import hdcpu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             T3,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D_IN,
  input  logic             SBUS,
  input  logic             ABUS,
  input  logic             DRW,
  input  logic [1:0]       RD,
  input  logic [3:0]       S,
  input  logic             M,
  input  logic             CIN,
  input  logic             LDC,
  input  logic             LDZ,
  output logic [WIDTH-1:0] RD_VAL,
  output logic             C,
  output logic             Z,
  output logic [CNT_W-1:0] BIT_CNT,
  output logic             FRAME_DONE,
  output logic             FRAME_ERR
);

  // state    | meaning
  // ST_IDLE  | no frame open, waiting for the first beat
  // ST_SHIFT | frame open, 1..WIDTH-1 beats received on frame_rd
  // ST_DONE  | WIDTH beats received; FRAME_DONE high for this cycle

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] regs [4];
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  state_t           state;
  logic [1:0]       frame_rd;

  logic sbus_wr, alu_wr, conflict, shift_op, beat, any_wr, frame_break;

  endpoint_alu #(.WIDTH(WIDTH)) u_alu (
    .a    (regs[RD]),
    .s    (S),
    .m    (M),
    .cin  (CIN),
    .res  (alu_res),
    .cout (alu_cout)
  );

  assign RD_VAL   = regs[RD];
  assign sbus_wr  = SBUS & ~ABUS;
  assign alu_wr   = ABUS & DRW & ~SBUS;
  assign conflict = SBUS & ABUS;
  assign shift_op = (S == S_SHIFT) & ~M;
  assign beat     = alu_wr & shift_op;
  assign any_wr   = sbus_wr | alu_wr;
  // Anything other than a same-register beat breaks an open frame.
  assign frame_break = conflict | (any_wr & ~beat) | (beat & (RD != frame_rd));

  always_ff @(posedge T3) begin
    if (CLR) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      C <= 1'b0;
      Z <= 1'b0;
    end else begin
      if (sbus_wr) regs[RD] <= D_IN;
      else if (alu_wr) regs[RD] <= alu_res;
      // Flags follow the ALU only when the bus is not carrying switch data.
      if (!SBUS) begin
        if (LDC) C <= alu_cout;
        if (LDZ) Z <= (alu_res == '0);
      end
    end
  end

  always_ff @(posedge T3) begin
    if (CLR) begin
      state      <= ST_IDLE;
      BIT_CNT    <= '0;
      frame_rd   <= R0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
      case (state)
        ST_SHIFT: begin
          if (frame_break) begin
            FRAME_ERR <= 1'b1;
            state     <= ST_IDLE;
            BIT_CNT   <= '0;
          end else if (beat) begin
            BIT_CNT <= BIT_CNT + CNT_ONE;
            if (BIT_CNT == CNT_LAST) begin
              state      <= ST_DONE;
              FRAME_DONE <= 1'b1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          BIT_CNT <= '0;
          if (conflict) begin
            FRAME_ERR <= 1'b1;
          end else if (beat) begin
            state    <= ST_SHIFT;
            BIT_CNT  <= CNT_ONE;
            frame_rd <= RD;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_endpoint.sv
// Directed bench for serial_shift_endpoint: a per-cycle reference model of
// registers, flags and frame counting, plus hand-computed spot checks.
module tb_serial_shift_endpoint;

  localparam int W = 8;

  logic       T3 = 1'b0;
  logic       CLR, SBUS, ABUS, DRW, M, CIN, LDC, LDZ;
  logic [7:0] D_IN;
  logic [1:0] RD;
  logic [3:0] S;
  logic [7:0] RD_VAL;
  logic       C, Z, FRAME_DONE, FRAME_ERR;
  logic [3:0] BIT_CNT;

  serial_shift_endpoint #(.WIDTH(8), .CNT_W(4)) dut (
    .T3(T3), .CLR(CLR), .D_IN(D_IN), .SBUS(SBUS), .ABUS(ABUS), .DRW(DRW),
    .RD(RD), .S(S), .M(M), .CIN(CIN), .LDC(LDC), .LDZ(LDZ),
    .RD_VAL(RD_VAL), .C(C), .Z(Z), .BIT_CNT(BIT_CNT),
    .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR)
  );

  always #5 T3 = ~T3;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Reference model state
  int m_regs [4];
  int m_c, m_z, m_cnt, m_frd, m_done, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge T3) begin
    if (chk_en) begin
      chk("rd_val", 32'(RD_VAL), 32'(m_regs[RD]));
      chk("c", 32'(C), 32'(m_c));
      chk("z", 32'(Z), 32'(m_z));
      chk("bit_cnt", 32'(BIT_CNT), 32'(m_cnt));
      chk("frame_done", 32'(FRAME_DONE), 32'(m_done));
      chk("frame_err", 32'(FRAME_ERR), 32'(m_err));
    end
  end

  task automatic cyc(input logic clr, sb, ab, dw, input logic [1:0] rd,
                     input logic [3:0] s, input logic m, ci, lc, lz,
                     input logic [7:0] d);
    int a, sum, res, cout;
    bit shift_op, wr_sw, wr_alu, conf, beat;
    CLR = clr; SBUS = sb; ABUS = ab; DRW = dw; RD = rd; S = s; M = m;
    CIN = ci; LDC = lc; LDZ = lz; D_IN = d;
    @(posedge T3);
    a = m_regs[rd];
    shift_op = (!m && s == 4'b1100);
    if (shift_op) sum = 2 * a + (ci ? 0 : 1);
    else if (!m && s == 4'b1001) sum = a + 1;
    else sum = a;
    res  = sum % 256;
    cout = sum / 256;
    conf   = sb && ab;
    wr_sw  = sb && !ab;
    wr_alu = ab && dw && !sb;
    beat   = wr_alu && shift_op;
    if (clr) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 0;
      m_c = 0; m_z = 0; m_cnt = 0; m_done = 0; m_err = 0;
    end else begin
      if (wr_sw) m_regs[rd] = d;
      else if (wr_alu) m_regs[rd] = res;
      if (!sb) begin
        if (lc) m_c = cout;
        if (lz) m_z = (res == 0) ? 1 : 0;
      end
      m_done = 0;
      m_err  = 0;
      if (conf) begin
        m_err = 1;
        m_cnt = 0;
      end else if (m_cnt > 0 && m_cnt < W) begin
        if (beat && int'(rd) == m_frd) begin
          m_cnt++;
          if (m_cnt == W) m_done = 1;
        end else if (wr_sw || wr_alu) begin
          m_err = 1;
          m_cnt = 0;
        end
      end else if (beat) begin
        m_cnt = 1;
        m_frd = int'(rd);
      end else begin
        m_cnt = 0;
      end
    end
    #1;
  endtask

  task automatic sw(input logic [1:0] rd, input logic [7:0] d);
    cyc(0, 1, 0, 0, rd, 4'h0, 0, 1, 0, 0, d);
  endtask

  task automatic bt(input logic [1:0] rd, input logic ci, lc, lz);
    cyc(0, 0, 1, 1, rd, 4'b1100, 0, ci, lc, lz, 8'h00);
  endtask

  task automatic idle(input logic [1:0] rd);
    cyc(0, 0, 0, 0, rd, 4'h0, 0, 1, 0, 0, 8'h00);
  endtask

  task automatic rst(input logic [1:0] rd);
    cyc(1, 0, 0, 0, rd, 4'h0, 0, 1, 0, 0, 8'h00);
  endtask

  initial begin
    logic [7:0] cseq;
    m_frd = 0;
    rst(0);
    rst(0);
    chk_en = 1;

    // Reset in the middle of a frame
    sw(3, 8'hFF);
    for (int i = 0; i < 3; i++) bt(3, 1, 1, 0);
    chk("t1_cnt_pre", 32'(BIT_CNT), 32'd3);
    chk("t1_c_pre", 32'(C), 32'd1);
    rst(3);
    chk("t1_r3", 32'(RD_VAL), 32'h00);
    chk("t1_c", 32'(C), 32'd0);
    chk("t1_cnt", 32'(BIT_CNT), 32'd0);
    chk("t1_err", 32'(FRAME_ERR), 32'd0);

    // Transmit A5: carry-out sequence is the word MSB first
    sw(3, 8'hA5);
    cseq = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      bt(3, 1, 1, 1);
      chk("t2_c", 32'(C), 32'(cseq[7-i]));
    end
    chk("t2_done", 32'(FRAME_DONE), 32'd1);
    chk("t2_cnt", 32'(BIT_CNT), 32'd8);
    chk("t2_z", 32'(Z), 32'd1);
    chk("t2_r3", 32'(RD_VAL), 32'h00);
    idle(3);
    chk("t2_done_off", 32'(FRAME_DONE), 32'd0);

    // Receive 1,0,1,0,... into R3
    for (int i = 0; i < 8; i++) begin
      bt(3, (i % 2 == 1), 0, 0);
      chk("t3_cnt", 32'(BIT_CNT), 32'(i + 1));
      chk("t3_done", 32'(FRAME_DONE), 32'(i == 7));
    end
    idle(3);
    chk("t3_r3", 32'(RD_VAL), 32'hAA);
    chk("t3_cnt_idle", 32'(BIT_CNT), 32'd0);

    // Foreign write aborts an open frame
    sw(1, 8'h3C);
    for (int i = 0; i < 3; i++) bt(3, 1, 0, 0);
    cyc(0, 0, 1, 1, 1, 4'b1111, 1, 1, 0, 0, 8'h00);
    chk("t4_err", 32'(FRAME_ERR), 32'd1);
    chk("t4_cnt", 32'(BIT_CNT), 32'd0);
    chk("t4_r1", 32'(RD_VAL), 32'h3C);
    idle(1);
    chk("t4_err_off", 32'(FRAME_ERR), 32'd0);
    bt(3, 1, 0, 0);
    chk("t4_restart", 32'(BIT_CNT), 32'd1);

    // Bus conflict: no write, no flag update, error pulse
    cyc(0, 1, 1, 1, 1, 4'b1100, 0, 0, 1, 1, 8'hFF);
    chk("t5_err", 32'(FRAME_ERR), 32'd1);
    chk("t5_r1", 32'(RD_VAL), 32'h3C);
    chk("t5_cnt", 32'(BIT_CNT), 32'd0);
    idle(1);
    chk("t5_err_off", 32'(FRAME_ERR), 32'd0);

    // Back-to-back frames
    sw(2, 8'h81);
    for (int i = 0; i < 8; i++) bt(2, 1, 1, 0);
    chk("t6_done", 32'(FRAME_DONE), 32'd1);
    chk("t6_cnt8", 32'(BIT_CNT), 32'd8);
    bt(2, 0, 1, 0);
    chk("t6_cnt1", 32'(BIT_CNT), 32'd1);
    chk("t6_r2a", 32'(RD_VAL), 32'h01);
    bt(2, 1, 0, 0);
    chk("t6_cnt2", 32'(BIT_CNT), 32'd2);
    chk("t6_r2b", 32'(RD_VAL), 32'h02);

    // Increment wraps and sets both flags; carry-in ignored
    rst(0);
    sw(0, 8'hFF);
    cyc(0, 0, 1, 1, 0, 4'b1001, 0, 0, 1, 1, 8'h00);
    chk("inc_r0", 32'(RD_VAL), 32'h00);
    chk("inc_c", 32'(C), 32'd1);
    chk("inc_z", 32'(Z), 32'd1);

    // Beat on another register aborts the frame
    bt(0, 1, 0, 0);
    bt(1, 1, 0, 0);
    chk("rd_switch_err", 32'(FRAME_ERR), 32'd1);
    chk("rd_switch_cnt", 32'(BIT_CNT), 32'd0);
    idle(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
